food_placer: RTL

FOOD_PLACER -- requirements
Module: food_placer

---
 rtl/food_placer.sv | 114 +++++++++++
 1 files changed

// File: rtl/food_placer.sv
// food_placer: samples LFSR coordinates, checks range and snake occupancy, commits a free cell as food.
module food_placer #(
  parameter int GRID_W    = 64,
  parameter int GRID_H    = 48,
  parameter int SKIP      = 10,
  parameter int MAX_TRIES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rand_x,
  input  logic [9:0] rand_y,
  input  logic       place_req,
  output logic       query_valid,
  output logic [5:0] query_x,
  output logic [5:0] query_y,
  input  logic       query_done,
  input  logic       query_hit,
  output logic [5:0] food_x,
  output logic [5:0] food_y,
  output logic       food_valid,
  output logic       busy,
  output logic       place_done,
  output logic       place_fail
);
  typedef enum logic [2:0] {IDLE, WAIT, SAMPLE, QUERY, COMMIT} state_t;
  state_t r_state, w_state;
  logic [7:0] r_skip, w_skip, r_try, w_try;
  logic [5:0] r_qx, w_qx, r_qy, w_qy, r_fx, w_fx, r_fy, w_fy;
  logic r_fv, w_fv, r_done, w_done, r_fail, w_fail, w_reject, w_in_range;
  logic w_unused;
  assign w_unused = ^{rand_x[9:6], rand_y[9:6]};
  assign w_in_range = ({1'b0, rand_x[5:0]} < 7'(GRID_W)) && ({1'b0, rand_y[5:0]} < 7'(GRID_H));
  always_comb begin
    w_state  = r_state;
    w_skip   = r_skip;
    w_try    = r_try;
    w_qx     = r_qx;
    w_qy     = r_qy;
    w_fx     = r_fx;
    w_fy     = r_fy;
    w_fv     = r_fv;
    w_done   = 1'b0;
    w_fail   = 1'b0;
    w_reject = 1'b0;
    case (r_state)
      IDLE: if (place_req) begin
        w_state = WAIT;
        w_fv    = 1'b0;
        w_try   = 8'd0;
        w_skip  = 8'(SKIP);
      end
      WAIT: if (r_skip == 8'd1) w_state = SAMPLE; else w_skip = r_skip - 8'd1;
      SAMPLE: if (w_in_range) begin
        w_qx    = rand_x[5:0];
        w_qy    = rand_y[5:0];
        w_state = QUERY;
      end else w_reject = 1'b1;
      QUERY: if (query_done && query_hit) w_reject = 1'b1; else if (query_done) w_state = COMMIT;
      COMMIT: begin
        w_fx    = r_qx;
        w_fy    = r_qy;
        w_fv    = 1'b1;
        w_done  = 1'b1;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
    // range miss and occupied cell share one retry/give-up path
    if (w_reject) begin
      if (r_try == 8'(MAX_TRIES - 1)) begin
        w_fail  = 1'b1;
        w_state = IDLE;
      end else begin
        w_try   = r_try + 8'd1;
        w_skip  = 8'(SKIP);
        w_state = WAIT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_skip  <= '0;
      r_try   <= '0;
      r_qx    <= '0;
      r_qy    <= '0;
      r_fx    <= '0;
      r_fy    <= '0;
      r_fv    <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_skip  <= w_skip;
      r_try   <= w_try;
      r_qx    <= w_qx;
      r_qy    <= w_qy;
      r_fx    <= w_fx;
      r_fy    <= w_fy;
      r_fv    <= w_fv;
      r_done  <= w_done;
      r_fail  <= w_fail;
    end
  end
  assign query_valid = r_state == QUERY;
  assign busy        = r_state != IDLE;
  assign query_x     = r_qx;
  assign query_y     = r_qy;
  assign food_x      = r_fx;
  assign food_y      = r_fy;
  assign food_valid  = r_fv;
  assign place_done  = r_done;
  assign place_fail  = r_fail;
endmodule
